// File: rtl/video_timing_gen.sv
// Runtime-configurable video timing generator: pixel coordinates, data enable,
// polarity-programmable syncs and line/frame strobes, all from one register stage.
module video_timing_gen #(
    parameter int HW        = 12,
    parameter int VW        = 11,
    parameter int H_DISPLAY = 800,
    parameter int H_FRONT   = 53,
    parameter int H_SYNC    = 120,
    parameter int H_BACK    = 61,
    parameter int V_DISPLAY = 600,
    parameter int V_FRONT   = 35,
    parameter int V_SYNC    = 6,
    parameter int V_BACK    = 21,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          en_i,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [HW-1:0] cfg_h_disp_i,
    input  logic [HW-1:0] cfg_h_fp_i,
    input  logic [HW-1:0] cfg_h_sync_i,
    input  logic [HW-1:0] cfg_h_bp_i,
    input  logic [VW-1:0] cfg_v_disp_i,
    input  logic [VW-1:0] cfg_v_fp_i,
    input  logic [VW-1:0] cfg_v_sync_i,
    input  logic [VW-1:0] cfg_v_bp_i,
    input  logic          cfg_hpol_i,
    input  logic          cfg_vpol_i,
    output logic          cfg_err_o,
    output logic [HW-1:0] hpos_o,
    output logic [VW-1:0] vpos_o,
    output logic          de_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          sol_o,
    output logic          sof_o,
    output logic          pix_stb_o
);
    localparam int HX = HW + 2;
    localparam int VX = VW + 2;
    localparam logic [HX-1:0] H_LIM = HX'(1) << HW;
    localparam logic [VX-1:0] V_LIM = VX'(1) << VW;

    logic [HW-1:0] a_hd, a_hf, a_hs, a_hb, p_hd, p_hf, p_hs, p_hb;
    logic [VW-1:0] a_vd, a_vf, a_vs, a_vb, p_vd, p_vf, p_vs, p_vb;
    logic          a_hpol, a_vpol, p_hpol, p_vpol;
    logic          p_full, started;

    logic [HX-1:0] in_htot, a_htot, t_hs_start, t_hs_end;
    logic [VX-1:0] in_vtot, a_vtot, t_vs_start, t_vs_end;
    logic          cfg_ok, xfer, h_last, v_last, frame_wrap, apply;
    logic [HW-1:0] nh, t_hd, t_hf, t_hs;
    logic [VW-1:0] nv, t_vd, t_vf, t_vs;
    logic          t_hpol, t_vpol, n_de, n_hact, n_vact;

    assign cfg_ready_o = ~p_full;
    assign xfer        = cfg_valid_i && !p_full;

    always_comb begin
        in_htot = HX'(cfg_h_disp_i) + HX'(cfg_h_fp_i) + HX'(cfg_h_sync_i) + HX'(cfg_h_bp_i);
        in_vtot = VX'(cfg_v_disp_i) + VX'(cfg_v_fp_i) + VX'(cfg_v_sync_i) + VX'(cfg_v_bp_i);
        cfg_ok  = (cfg_h_disp_i != '0) && (cfg_h_sync_i != '0) &&
                  (cfg_v_disp_i != '0) && (cfg_v_sync_i != '0) &&
                  (in_htot <= H_LIM) && (in_vtot <= V_LIM);
    end

    // Wrap detection uses the running timing; the outputs of the wrapped-to
    // pixel use the pending timing when it is applied on this edge.
    always_comb begin
        a_htot = HX'(a_hd) + HX'(a_hf) + HX'(a_hs) + HX'(a_hb);
        a_vtot = VX'(a_vd) + VX'(a_vf) + VX'(a_vs) + VX'(a_vb);
        h_last = (HX'(hpos_o) == a_htot - HX'(1));
        v_last = (VX'(vpos_o) == a_vtot - VX'(1));
        nh = '0;
        nv = '0;
        frame_wrap = 1'b1;
        if (started) begin
            nh = h_last ? '0 : hpos_o + HW'(1);
            nv = h_last ? (v_last ? '0 : vpos_o + VW'(1)) : vpos_o;
            frame_wrap = h_last && v_last;
        end
        apply = en_i && frame_wrap && p_full;

        t_hd   = apply ? p_hd   : a_hd;
        t_hf   = apply ? p_hf   : a_hf;
        t_hs   = apply ? p_hs   : a_hs;
        t_vd   = apply ? p_vd   : a_vd;
        t_vf   = apply ? p_vf   : a_vf;
        t_vs   = apply ? p_vs   : a_vs;
        t_hpol = apply ? p_hpol : a_hpol;
        t_vpol = apply ? p_vpol : a_vpol;

        t_hs_start = HX'(t_hd) + HX'(t_hf);
        t_hs_end   = t_hs_start + HX'(t_hs);
        t_vs_start = VX'(t_vd) + VX'(t_vf);
        t_vs_end   = t_vs_start + VX'(t_vs);
        n_de   = (nh < t_hd) && (nv < t_vd);
        n_hact = (HX'(nh) >= t_hs_start) && (HX'(nh) < t_hs_end);
        n_vact = (VX'(nv) >= t_vs_start) && (VX'(nv) < t_vs_end);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_hd <= HW'(H_DISPLAY); a_hf <= HW'(H_FRONT); a_hs <= HW'(H_SYNC); a_hb <= HW'(H_BACK);
            a_vd <= VW'(V_DISPLAY); a_vf <= VW'(V_FRONT); a_vs <= VW'(V_SYNC); a_vb <= VW'(V_BACK);
            a_hpol <= HSYNC_POL;
            a_vpol <= VSYNC_POL;
            p_hd <= '0; p_hf <= '0; p_hs <= '0; p_hb <= '0;
            p_vd <= '0; p_vf <= '0; p_vs <= '0; p_vb <= '0;
            p_hpol <= 1'b0;
            p_vpol <= 1'b0;
            p_full    <= 1'b0;
            started   <= 1'b0;
            cfg_err_o <= 1'b0;
            hpos_o    <= '0;
            vpos_o    <= '0;
            de_o      <= 1'b0;
            hsync_o   <= ~HSYNC_POL;
            vsync_o   <= ~VSYNC_POL;
            sol_o     <= 1'b0;
            sof_o     <= 1'b0;
            pix_stb_o <= 1'b0;
        end else begin
            cfg_err_o <= xfer && !cfg_ok;
            if (xfer && cfg_ok) begin
                p_hd <= cfg_h_disp_i; p_hf <= cfg_h_fp_i; p_hs <= cfg_h_sync_i; p_hb <= cfg_h_bp_i;
                p_vd <= cfg_v_disp_i; p_vf <= cfg_v_fp_i; p_vs <= cfg_v_sync_i; p_vb <= cfg_v_bp_i;
                p_hpol <= cfg_hpol_i;
                p_vpol <= cfg_vpol_i;
                p_full <= 1'b1;
            end
            if (en_i) begin
                started   <= 1'b1;
                hpos_o    <= nh;
                vpos_o    <= nv;
                de_o      <= n_de;
                hsync_o   <= n_hact ? t_hpol : ~t_hpol;
                vsync_o   <= n_vact ? t_vpol : ~t_vpol;
                sol_o     <= (nh == '0);
                sof_o     <= frame_wrap;
                pix_stb_o <= 1'b1;
                if (apply) begin
                    a_hd <= p_hd; a_hf <= p_hf; a_hs <= p_hs; a_hb <= p_hb;
                    a_vd <= p_vd; a_vf <= p_vf; a_vs <= p_vs; a_vb <= p_vb;
                    a_hpol <= p_hpol;
                    a_vpol <= p_vpol;
                    p_full <= 1'b0;
                end
            end else begin
                sol_o     <= 1'b0;
                sof_o     <= 1'b0;
                pix_stb_o <= 1'b0;
            end
        end
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed-mode HV sync generator.
- Produces pixel coordinates, data-enable, and hsync/vsync with configurable polarity, plus line/frame start strobes.
- Timings are loadable at runtime through a valid/ready config port and take effect only at a frame boundary, so mode changes are tear-free.
- Sits between the pixel clock domain logic and the pattern/framebuffer readers.

Parameters:
- HW, 12, horizontal counter/field width
- VW, 11, vertical counter/field width
- H_DISPLAY, 800, active pixels per line (reset mode)
- H_FRONT, 53, horizontal front porch
- H_SYNC, 120, hsync width
- H_BACK, 61, horizontal back porch
- V_DISPLAY, 600, active lines
- V_FRONT, 35, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 21, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync_o
- VSYNC_POL, 0, active level of vsync_o

Ports:
- clk_i  in  1  pixel clock
- rstn_i  in  1  asynchronous active-low reset
- en_i  in  1  pixel advance enable (clock enable)
- cfg_valid_i  in  1  new timing set offered
- cfg_ready_o  out  1  config slot free
- cfg_h_disp_i, cfg_h_fp_i, cfg_h_sync_i, cfg_h_bp_i  in  HW each  horizontal timing fields
- cfg_v_disp_i, cfg_v_fp_i, cfg_v_sync_i, cfg_v_bp_i  in  VW each  vertical timing fields
- cfg_hpol_i, cfg_vpol_i  in  1 each  sync polarities
- cfg_err_o  out  1  one-cycle pulse: accepted config rejected
- hpos_o  out  HW  current pixel x
- vpos_o  out  VW  current line y
- de_o  out  1  pixel in active area
- hsync_o, vsync_o  out  1 each  syncs at configured polarity
- sol_o  out  1  start of line (hpos 0), one-cycle
- sof_o  out  1  start of frame (0,0), one-cycle
- pix_stb_o  out  1  outputs describe a newly advanced pixel this cycle

Behaviour:
- Reset (async assert, sync release): active config = parameter values; pending slot empty; cfg_ready_o=1; started=0.
- Reset output values: hpos_o=0, vpos_o=0, de_o=0, sol_o=0, sof_o=0, pix_stb_o=0, cfg_err_o=0, hsync_o=~HSYNC_POL, vsync_o=~VSYNC_POL.
- All outputs are registered and mutually aligned: hpos/vpos/de/syncs/strobes on the same cycle describe the same pixel. There is no one-cycle sync skew.
- Line order: display, front porch, sync, back porch. Frame order is the same in lines.
- HTOT = sum of the four H fields. hsync is active for hpos in [disp+fp, disp+fp+sync-1]. Vertical timing is analogous.
- de_o = (hpos < h_disp) && (vpos < v_disp).
- Edge with en_i=1, started=0:
  - Apply the pending config if present.
  - Output pixel (0,0); sof_o=sol_o=pix_stb_o=1; set started=1.
- Edge with en_i=1, started=1:
  - hpos wraps to 0 at HTOT-1 and asserts sol_o; otherwise hpos increments.
  - vpos increments on the hpos wrap and wraps to 0 at VTOT-1.
  - (0,0) asserts sof_o. pix_stb_o=1.
- Edge with en_i=0: position, de and syncs hold; sol_o, sof_o, pix_stb_o forced 0.
- Config handshake:
  - Transfer occurs on cfg_valid_i && cfg_ready_o. Fields are captured into the pending slot; cfg_ready_o=0 next cycle.
  - Validation at capture: h_disp, h_sync, v_disp, v_sync must be nonzero, and HTOT ≤ 2^HW and VTOT ≤ 2^VW (sums computed at width+2).
  - On failure: slot not filled, cfg_err_o pulses 1 cycle, cfg_ready_o stays 1.
  - A valid pending config is applied on the enabled edge that wraps to (0,0), or on the first start. The new frame's (0,0) outputs already use the new timing. cfg_ready_o returns to 1 the cycle after application.
  - Fields are not re-read after capture.
- Simultaneous events: a transfer on the same edge as a wrap is not applied to that wrap; it waits one full frame.
- en_i low indefinitely blocks application; cfg_ready_o stays 0.
- Reset mid-frame or mid-handshake discards pending config and returns to parameter timing.

Test Plan:
- Params H 8/2/3/1, V 4/1/2/1, pols 0, en_i=1 after reset:
  - First edge gives (0,0), sof=sol=1, de=1.
  - hsync_o low exactly at hpos 10..12; HTOT=14.
  - vsync_o low for vpos 5..6; VTOT=8.
  - sof repeats every 112 cycles.
- en_i toggled 1/0 every cycle: position advances every second edge; pix_stb_o, sol_o, sof_o high only on advance edges; a full frame takes 224 cycles.
- Config H 4/1/1/1, V 2/1/1/1, pols 1, offered mid-frame:
  - cfg_ready_o drops next cycle.
  - Old timing continues until the wrap; next frame has HTOT=7 and VTOT=5 with active-high syncs.
  - cfg_ready_o rises one cycle after the new (0,0).
- Config with h_sync=0: cfg_err_o single pulse, cfg_ready_o remains 1, timing unchanged.
- Config with HTOT=4097 at HW=12: rejected with cfg_err_o pulse.
- Config offered on the exact wrap edge: not applied until the following frame's wrap.
- rstn_i asserted mid-frame with config pending: all outputs immediately at reset values and cfg_ready_o=1; the next frame uses parameter timing.
